// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle MIPS control sequencer: FETCH/DECODE/EXEC/MEM/WB walk with
// memory-ready stalls, wait-cycle timeout trap and illegal-opcode trap.
//
// Ports:
//   clk, rst_n        clock (rising edge), synchronous active-low reset
//   OPCode[5:0]       IR[31:26], looked at in DECODE and MEMADR only
//   Zero              ALU zero flag, qualifies the beq PC load
//   mem_ready         shared memory finishes the current access this cycle
//   PCWrite..PCSource datapath strobes and mux selects, decoded from state
//   state[3:0]        current state encoding (debug)
//   illegal_op        sticky: unsupported opcode reached DECODE
//   mem_err           sticky: memory wait exceeded TIMEOUT cycles
module multicycle_ctrl_fsm #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] OPCode,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUop,
    output logic [1:0] PCSource,
    output logic [3:0] state,
    output logic       illegal_op,
    output logic       mem_err
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXEC  = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11,
        S_TRAP   = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;
    logic             mem_err_q, mem_err_d;

    logic       pcw_s, pcwc_s, iord_s, mrd_s, mwr_s, irw_s;
    logic       m2r_s, rdst_s, rw_s, asa_s;
    logic [1:0] asb_s, aluop_s, pcsrc_s;
    logic       is_mem;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            mem_err_q <= mem_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        illegal_d = illegal_q;
        mem_err_d = mem_err_q;
        pcw_s     = 1'b0;
        pcwc_s    = 1'b0;
        iord_s    = 1'b0;
        mrd_s     = 1'b0;
        mwr_s     = 1'b0;
        irw_s     = 1'b0;
        m2r_s     = 1'b0;
        rdst_s    = 1'b0;
        rw_s      = 1'b0;
        asa_s     = 1'b0;
        asb_s     = 2'd0;
        aluop_s   = 2'd0;
        pcsrc_s   = 2'd0;
        is_mem    = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                is_mem = 1'b1;
                mrd_s  = 1'b1;
                asb_s  = 2'd1;
                irw_s  = mem_ready;
                pcw_s  = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                asb_s = 2'd3;
                unique case (OPCode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_REXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_IEXEC;
                    default: begin
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                asa_s   = 1'b1;
                asb_s   = 2'd2;
                state_d = (OPCode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                is_mem = 1'b1;
                mrd_s  = 1'b1;
                iord_s = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                rw_s    = 1'b1;
                m2r_s   = 1'b1;
                state_d = S_FETCH;
            end
            S_MEMWR: begin
                is_mem = 1'b1;
                mwr_s  = 1'b1;
                iord_s = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_REXEC: begin
                asa_s   = 1'b1;
                aluop_s = 2'd2;
                state_d = S_RWB;
            end
            S_RWB: begin
                rw_s    = 1'b1;
                rdst_s  = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                asa_s   = 1'b1;
                aluop_s = 2'd1;
                pcwc_s  = Zero;
                pcsrc_s = 2'd1;
                state_d = S_FETCH;
            end
            S_JUMP: begin
                pcw_s   = 1'b1;
                pcsrc_s = 2'd2;
                state_d = S_FETCH;
            end
            S_IEXEC: begin
                asa_s   = 1'b1;
                asb_s   = 2'd2;
                state_d = S_IWB;
            end
            S_IWB: begin
                rw_s    = 1'b1;
                state_d = S_FETCH;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase

        // Counter clears by default; a ready on the last wait cycle
        // never reaches this branch, so it beats the timeout.
        if (is_mem && !mem_ready) begin
            if (cnt_q == CNT_LAST) begin
                state_d   = S_TRAP;
                mem_err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Strobes are gated by reset so an aborted instruction writes nothing.
    assign PCWrite     = rst_n & pcw_s;
    assign PCWriteCond = rst_n & pcwc_s;
    assign IorD        = rst_n & iord_s;
    assign MemRead     = rst_n & mrd_s;
    assign MemWrite    = rst_n & mwr_s;
    assign IRWrite     = rst_n & irw_s;
    assign MemtoReg    = rst_n & m2r_s;
    assign RegDst      = rst_n & rdst_s;
    assign RegWrite    = rst_n & rw_s;
    assign ALUSrcA     = rst_n & asa_s;
    assign ALUSrcB     = rst_n ? asb_s : 2'd0;
    assign ALUop       = rst_n ? aluop_s : 2'd0;
    assign PCSource    = rst_n ? pcsrc_s : 2'd0;
    assign state       = state_q;
    assign illegal_op  = illegal_q;
    assign mem_err     = mem_err_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: vector table through a scoreboard queue,
// then hand sequences for trap, mid-instruction reset and wait timeout.
module tb_multicycle_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] OPCode;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUop, PCSource;
    logic [3:0] state;
    logic       illegal_op, mem_err;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .OPCode(OPCode), .Zero(Zero),
        .mem_ready(mem_ready), .PCWrite(PCWrite),
        .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
        .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUop(ALUop), .PCSource(PCSource),
        .state(state), .illegal_op(illegal_op), .mem_err(mem_err)
    );

    // Strobe word order:
    // PCWrite PCWriteCond IorD MemRead MemWrite IRWrite
    // MemtoReg RegDst RegWrite ALUSrcA ALUSrcB ALUop PCSource
    localparam logic [15:0] X_NONE = 16'h0000;
    localparam logic [15:0] X_FETCH_R =
        {6'b100101, 4'b0000, 2'd1, 2'd0, 2'd0};
    localparam logic [15:0] X_FETCH_W =
        {6'b000100, 4'b0000, 2'd1, 2'd0, 2'd0};
    localparam logic [15:0] X_DECODE =
        {6'b000000, 4'b0000, 2'd3, 2'd0, 2'd0};
    localparam logic [15:0] X_MEMADR =
        {6'b000000, 4'b0001, 2'd2, 2'd0, 2'd0};
    localparam logic [15:0] X_MEMRD =
        {6'b001100, 4'b0000, 2'd0, 2'd0, 2'd0};
    localparam logic [15:0] X_MEMWB =
        {6'b000000, 4'b1010, 2'd0, 2'd0, 2'd0};
    localparam logic [15:0] X_MEMWR =
        {6'b001010, 4'b0000, 2'd0, 2'd0, 2'd0};
    localparam logic [15:0] X_REXEC =
        {6'b000000, 4'b0001, 2'd0, 2'd2, 2'd0};
    localparam logic [15:0] X_RWB =
        {6'b000000, 4'b0110, 2'd0, 2'd0, 2'd0};
    localparam logic [15:0] X_BRANCH =
        {6'b010000, 4'b0001, 2'd0, 2'd1, 2'd1};
    localparam logic [15:0] X_JUMP =
        {6'b100000, 4'b0000, 2'd0, 2'd0, 2'd2};
    localparam logic [15:0] X_IEXEC =
        {6'b000000, 4'b0001, 2'd2, 2'd0, 2'd0};
    localparam logic [15:0] X_IWB =
        {6'b000000, 4'b0010, 2'd0, 2'd0, 2'd0};

    typedef struct {
        logic        cs;
        logic [3:0]  st;
        logic [15:0] str;
        logic        ill;
        logic        err;
        string       nm;
    } exp_t;

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic       z;
        logic       rdy;
        exp_t       e;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    function automatic exp_t ex(input logic cs, input logic [3:0] st,
                                input logic [15:0] str, input logic ill,
                                input logic err, input string nm);
        exp_t e;
        e.cs = cs; e.st = st; e.str = str;
        e.ill = ill; e.err = err; e.nm = nm;
        return e;
    endfunction

    function automatic vec_t vv(input logic rst, input logic [5:0] op,
                                input logic z, input logic rdy,
                                input exp_t e);
        vec_t v;
        v.rst = rst; v.op = op; v.z = z; v.rdy = rdy; v.e = e;
        return v;
    endfunction

    task automatic check();
        exp_t        e;
        logic [15:0] a;
        logic        ok;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL scoreboard: queue empty, no expectation");
            return;
        end
        e = sb.pop_front();
        a = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
             MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUop,
             PCSource};
        ok = (a === e.str);
        if (e.cs)
            ok = ok && (state === e.st) && (illegal_op === e.ill)
                    && (mem_err === e.err);
        if (!ok) begin
            bad++;
            $display("FAIL %s: got st=%0d str=%h ill=%b err=%b want st=%0d str=%h ill=%b err=%b",
                     e.nm, state, a, illegal_op, mem_err,
                     e.st, e.str, e.ill, e.err);
        end
    endtask

    task automatic step(input logic rst, input logic [5:0] op,
                        input logic z, input logic rdy, input exp_t e);
        @(negedge clk);
        rst_n = rst; OPCode = op; Zero = z; mem_ready = rdy;
        sb.push_back(e);
        #2;
        check();
    endtask

    initial begin
        rst_n = 1'b0; OPCode = 6'd0; Zero = 1'b0; mem_ready = 1'b1;

        // reset, R-type
        tbl.push_back(vv(0, 6'h00, 0, 1, ex(0, 0, X_NONE, 0, 0, "rst0")));
        tbl.push_back(vv(0, 6'h00, 0, 1, ex(1, 0, X_NONE, 0, 0, "rst1")));
        tbl.push_back(vv(1, 6'h00, 0, 1, ex(1, 0, X_FETCH_R, 0, 0, "r_f")));
        tbl.push_back(vv(1, 6'h00, 0, 1, ex(1, 1, X_DECODE, 0, 0, "r_d")));
        tbl.push_back(vv(1, 6'h00, 0, 1, ex(1, 6, X_REXEC, 0, 0, "r_ex")));
        tbl.push_back(vv(1, 6'h00, 0, 1, ex(1, 7, X_RWB, 0, 0, "r_wb")));
        // lw with three wait cycles in MEMRD
        tbl.push_back(vv(1, 6'h23, 0, 1, ex(1, 0, X_FETCH_R, 0, 0, "lw_f")));
        tbl.push_back(vv(1, 6'h23, 0, 1, ex(1, 1, X_DECODE, 0, 0, "lw_d")));
        tbl.push_back(vv(1, 6'h23, 0, 1, ex(1, 2, X_MEMADR, 0, 0, "lw_a")));
        tbl.push_back(vv(1, 6'h23, 0, 0, ex(1, 3, X_MEMRD, 0, 0, "lw_w1")));
        tbl.push_back(vv(1, 6'h23, 0, 0, ex(1, 3, X_MEMRD, 0, 0, "lw_w2")));
        tbl.push_back(vv(1, 6'h23, 0, 0, ex(1, 3, X_MEMRD, 0, 0, "lw_w3")));
        tbl.push_back(vv(1, 6'h23, 0, 1, ex(1, 3, X_MEMRD, 0, 0, "lw_rd")));
        tbl.push_back(vv(1, 6'h23, 0, 1, ex(1, 4, X_MEMWB, 0, 0, "lw_wb")));
        // beq taken
        tbl.push_back(vv(1, 6'h04, 1, 1, ex(1, 0, X_FETCH_R, 0, 0, "beq_f")));
        tbl.push_back(vv(1, 6'h04, 1, 1, ex(1, 1, X_DECODE, 0, 0, "beq_d")));
        tbl.push_back(vv(1, 6'h04, 1, 1, ex(1, 8, X_BRANCH, 0, 0, "beq_b")));
        // sw
        tbl.push_back(vv(1, 6'h2B, 0, 1, ex(1, 0, X_FETCH_R, 0, 0, "sw_f")));
        tbl.push_back(vv(1, 6'h2B, 0, 1, ex(1, 1, X_DECODE, 0, 0, "sw_d")));
        tbl.push_back(vv(1, 6'h2B, 0, 1, ex(1, 2, X_MEMADR, 0, 0, "sw_a")));
        tbl.push_back(vv(1, 6'h2B, 0, 1, ex(1, 5, X_MEMWR, 0, 0, "sw_w")));
        // addi
        tbl.push_back(vv(1, 6'h08, 0, 1, ex(1, 0, X_FETCH_R, 0, 0, "ai_f")));
        tbl.push_back(vv(1, 6'h08, 0, 1, ex(1, 1, X_DECODE, 0, 0, "ai_d")));
        tbl.push_back(vv(1, 6'h08, 0, 1, ex(1, 10, X_IEXEC, 0, 0, "ai_ex")));
        tbl.push_back(vv(1, 6'h08, 0, 1, ex(1, 11, X_IWB, 0, 0, "ai_wb")));
        // j
        tbl.push_back(vv(1, 6'h02, 0, 1, ex(1, 0, X_FETCH_R, 0, 0, "j_f")));
        tbl.push_back(vv(1, 6'h02, 0, 1, ex(1, 1, X_DECODE, 0, 0, "j_d")));
        tbl.push_back(vv(1, 6'h02, 0, 1, ex(1, 9, X_JUMP, 0, 0, "j_j")));
        // one fetch wait, then opcode churn outside DECODE is ignored
        tbl.push_back(vv(1, 6'h00, 0, 0, ex(1, 0, X_FETCH_W, 0, 0, "fw_w")));
        tbl.push_back(vv(1, 6'h00, 0, 1, ex(1, 0, X_FETCH_R, 0, 0, "fw_r")));
        tbl.push_back(vv(1, 6'h00, 0, 1, ex(1, 1, X_DECODE, 0, 0, "ig_d")));
        tbl.push_back(vv(1, 6'h3F, 0, 1, ex(1, 6, X_REXEC, 0, 0, "ig_ex")));
        tbl.push_back(vv(1, 6'h3F, 0, 1, ex(1, 7, X_RWB, 0, 0, "ig_wb")));
        tbl.push_back(vv(1, 6'h00, 0, 1, ex(1, 0, X_FETCH_R, 0, 0, "ig_f")));

        foreach (tbl[i])
            step(tbl[i].rst, tbl[i].op, tbl[i].z, tbl[i].rdy, tbl[i].e);

        // illegal opcode: trap is held, sticky until reset
        step(1, 6'h3F, 0, 1, ex(1, 1, X_DECODE, 0, 0, "il_d"));
        for (int i = 0; i < 3; i++)
            step(1, 6'h00, 0, i[0], ex(1, 12, X_NONE, 1, 0, "il_trap"));
        step(0, 6'h00, 0, 1, ex(1, 12, X_NONE, 1, 0, "il_rst"));
        step(1, 6'h00, 0, 1, ex(1, 0, X_FETCH_R, 0, 0, "il_clr"));

        // reset in the middle of a stalled store writes nothing
        step(1, 6'h2B, 0, 1, ex(1, 1, X_DECODE, 0, 0, "ab_d"));
        step(1, 6'h2B, 0, 1, ex(1, 2, X_MEMADR, 0, 0, "ab_a"));
        step(1, 6'h2B, 0, 0, ex(1, 5, X_MEMWR, 0, 0, "ab_w"));
        step(0, 6'h2B, 0, 0, ex(1, 5, X_NONE, 0, 0, "ab_rst"));
        step(1, 6'h00, 0, 1, ex(1, 0, X_FETCH_R, 0, 0, "ab_f"));

        // ready arriving on the last allowed wait cycle wins
        step(1, 6'h00, 0, 1, ex(1, 1, X_DECODE, 0, 0, "tb_d"));
        step(1, 6'h00, 0, 1, ex(1, 6, X_REXEC, 0, 0, "tb_ex"));
        step(1, 6'h00, 0, 1, ex(1, 7, X_RWB, 0, 0, "tb_wb"));
        for (int i = 0; i < 15; i++)
            step(1, 6'h00, 0, 0, ex(1, 0, X_FETCH_W, 0, 0, "tb_wait"));
        step(1, 6'h00, 0, 1, ex(1, 0, X_FETCH_R, 0, 0, "tb_last"));
        step(1, 6'h00, 0, 1, ex(1, 1, X_DECODE, 0, 0, "to_d"));
        step(1, 6'h00, 0, 1, ex(1, 6, X_REXEC, 0, 0, "to_ex"));
        step(1, 6'h00, 0, 1, ex(1, 7, X_RWB, 0, 0, "to_wb"));

        // sixteen waits in FETCH: timeout trap
        for (int i = 0; i < 16; i++)
            step(1, 6'h00, 0, 0, ex(1, 0, X_FETCH_W, 0, 0, "to_wait"));
        for (int i = 0; i < 3; i++)
            step(1, 6'h00, 0, 1, ex(1, 12, X_NONE, 0, 1, "to_trap"));

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard: %0d left, want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
